// File: rtl/doodle_pkg.sv
// Shared geometry, FSM encoding and helpers for the platform scroll scheduler.
// Row positions are signed 11-bit screen y; scan arithmetic is done at 12 bits.
package doodle_pkg;

    localparam int NUM_ROWS   = 31;
    localparam int NUM_COLS   = 3;
    localparam int ROW_PITCH  = 30;
    localparam int ROW_Y0     = -162;
    localparam int SCREEN_H   = 768;
    localparam int ROW_SPAN   = 930;
    localparam int MAX_SCROLL = 29;

    localparam int ROW_W  = 5;
    localparam int Y_W    = 11;
    localparam int CALC_W = 12;
    localparam int AMT_W  = 5;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic signed [Y_W-1:0] row_init_y(input int r);
        return Y_W'(ROW_Y0 + ROW_PITCH * r);
    endfunction

    // A fresh row always gets at least one active column: an all-zero random
    // pattern falls back to a single column picked from two further bits.
    function automatic logic [NUM_COLS-1:0] pick_act(input logic [4:0] bits);
        if (bits[2:0] != 3'b000) begin
            return bits[2:0];
        end
        case (bits[4:3])
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/random_sonya_coin.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that steps every clock.
// Reset reloads the fixed nonzero seed so platform patterns repeat after reset.
module random_sonya_coin
    import doodle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rand_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_o = lfsr_q;

endmodule

// File: rtl/platform_scroll_scheduler.sv
// Per-frame scroll scan: moves all 31 platform rows down by the requested amount,
// one row per cycle, recycling rows that fall off the bottom back to the top.
module platform_scroll_scheduler
    import doodle_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [5:0]            scroll_amt,
    output logic                  wr_en,
    output logic [ROW_W-1:0]      wr_row,
    output logic signed [Y_W-1:0] wr_y,
    output logic [NUM_COLS-1:0]   wr_act,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [15:0]           rows_recycled
);

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_cnt_q, row_cnt_d;
    logic [AMT_W-1:0]        amt_q, amt_d;
    logic signed [Y_W-1:0]   row_y_q [NUM_ROWS];
    logic signed [Y_W-1:0]   row_y_d [NUM_ROWS];
    logic [NUM_COLS-1:0]     act_q [NUM_ROWS];
    logic [NUM_COLS-1:0]     act_d [NUM_ROWS];
    logic                    overrun_q, overrun_d;
    logic [15:0]             recycled_q, recycled_d;
    logic                    done_q, done_d;

    logic [15:0]             lfsr_val;
    logic                    unused_lfsr_bits;
    logic signed [Y_W-1:0]   cur_y;
    logic signed [CALC_W-1:0] sum_y;
    logic signed [CALC_W-1:0] new_y;
    logic                    recycle;
    logic [NUM_COLS-1:0]     fresh_act;

    random_sonya_coin u_rng (
        .clk    (clk),
        .rst    (rst),
        .rand_o (lfsr_val)
    );

    assign unused_lfsr_bits = ^lfsr_val[15:5];

    // Since the scroll amount is below the row pitch, one subtraction of the
    // span is enough to bring any row back inside the visible band.
    always_comb begin
        cur_y     = row_y_q[row_cnt_q];
        sum_y     = CALC_W'(cur_y) + $signed({{(CALC_W-AMT_W){1'b0}}, amt_q});
        recycle   = (sum_y >= $signed(CALC_W'(SCREEN_H)));
        new_y     = recycle ? (sum_y - $signed(CALC_W'(ROW_SPAN))) : sum_y;
        fresh_act = pick_act(lfsr_val[4:0]);
    end

    // NOTE: every signal written below gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        amt_d      = amt_q;
        row_y_d    = row_y_q;
        act_d      = act_q;
        overrun_d  = overrun_q;
        recycled_d = recycled_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        wr_row     = '0;
        wr_y       = '0;
        wr_act     = '0;
        busy       = 1'b0;

        if (frame_start && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start && (scroll_amt != 6'd0)) begin
                    state_d   = ST_SCAN;
                    row_cnt_d = '0;
                    amt_d     = (scroll_amt > 6'(MAX_SCROLL)) ? AMT_W'(MAX_SCROLL)
                                                             : scroll_amt[AMT_W-1:0];
                end
            end
            ST_SCAN: begin
                busy   = 1'b1;
                wr_en  = 1'b1;
                wr_row = row_cnt_q;
                wr_y   = new_y[Y_W-1:0];
                wr_act = recycle ? fresh_act : act_q[row_cnt_q];
                row_y_d[row_cnt_q] = new_y[Y_W-1:0];
                if (recycle) begin
                    act_d[row_cnt_q] = fresh_act;
                    recycled_d       = recycled_q + 16'd1;
                end
                if (row_cnt_q == ROW_W'(NUM_ROWS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the row table is reset explicitly because it is the authoritative
    // platform layout, not scratch storage that gets overwritten before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_cnt_q  <= '0;
            amt_q      <= '0;
            overrun_q  <= 1'b0;
            recycled_q <= '0;
            done_q     <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                row_y_q[r] <= row_init_y(r);
                act_q[r]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            amt_q      <= amt_d;
            overrun_q  <= overrun_d;
            recycled_q <= recycled_d;
            done_q     <= done_d;
            row_y_q    <= row_y_d;
            act_q      <= act_d;
        end
    end

    // done is registered off the DONE state, landing 33 cycles after frame_start.
    assign done          = done_q;
    assign overrun       = overrun_q;
    assign rows_recycled = recycled_q;

endmodule

// File: doc/platform_scroll_scheduler.md
PLATFORM_SCROLL_SCHEDULER -- requirements
Module: platform_scroll_scheduler

Interface
REQ-001 clk  input  1  system clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-004 scroll_amt  input  6  unsigned downward scroll request in pixels for the coming frame.
REQ-005 wr_en  output  1  row write strobe toward the platform store.
REQ-006 wr_row  output  5  row index 0..30 being written.
REQ-007 wr_y  output  11  signed new top y of that row.
REQ-008 wr_act  output  3  activation bits for columns 0..2 of that row.
REQ-009 busy  output  1  high while a scan is in progress.
REQ-010 done  output  1  one-cycle pulse when a scan completes.
REQ-011 overrun  output  1  sticky flag: frame_start arrived while busy.
REQ-012 rows_recycled  output  16  count of rows regenerated since reset, wraps modulo 2^16.

Function
REQ-013 Geometry: 31 rows x 3 columns; row pitch 30; row r initial y = -162 + 30*r; span 930; visible limit 768.
REQ-014 Internal row_y[31] (signed 11-bit) is the authoritative row position.
REQ-015 FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-016 IDLE -> SCAN on frame_start with scroll_amt != 0; amt_q = min(scroll_amt, 29) latched that cycle; row counter cleared.
REQ-017 frame_start with scroll_amt == 0 in IDLE: no transition, no writes, no done pulse.
REQ-018 SCAN processes one row per cycle, rows 0..30 in order; wr_en high exactly 31 consecutive cycles, first in the cycle after the accepting frame_start.
REQ-019 Per row: ny = row_y + amt_q; if ny >= 768 then ny = ny - 930 and row is recycled, else not recycled.
REQ-020 Non-recycled row: wr_y = ny, wr_act = 3'b000 is NOT written; wr_act carries the row's stored activation unchanged (controller keeps act_q[31][3]).
REQ-021 Recycled row: wr_act = lfsr[2:0]; if lfsr[2:0] == 0, wr_act = one-hot column (lfsr[4:3] mod 3); act_q and row_y updated; rows_recycled increments by 1.
REQ-022 LFSR advances every clock regardless of state; recycled rows in one scan take bits from successive LFSR states.
REQ-023 After row 30: SCAN -> DONE; DONE asserts done for one cycle, busy low, -> IDLE.
REQ-024 busy = 1 in SCAN only; latency frame_start to done = 33 cycles.
REQ-025 frame_start while busy or in DONE: ignored, overrun set to 1, held until rst.
REQ-026 Arithmetic in 12-bit signed internally; row_y always within [-162, 767] after any scan.
REQ-027 amt_q <= 29 < pitch guarantees at most one wrap per row per scan.

Reset
REQ-028 On rst: state IDLE, wr_en 0, wr_row 0, wr_y 0, wr_act 0, busy 0, done 0, overrun 0, rows_recycled 0.
REQ-029 On rst: row_y[r] = -162 + 30*r; act_q[r] = 3'b000 for all r; LFSR reseeded to its fixed nonzero seed.
REQ-030 rst asserted mid-scan aborts immediately; no further wr_en after the reset cycle.

Structure
REQ-031 Shared package doodle_pkg holds NUM_ROWS=31, NUM_COLS=3, ROW_PITCH=30, ROW_Y0=-162, SCREEN_H=768, ROW_SPAN=930, MAX_SCROLL=29 and the FSM state enum.
REQ-032 Single sub-module: random_sonya_coin instance supplying the 16-bit LFSR value.

Verification
REQ-033 rst, frame_start with scroll_amt=10 -> 31 writes; row 0 wr_y=-152, row 30 wr_y=748; no recycle; done 33 cycles after frame_start.
REQ-034 Repeat scroll_amt=10 twice more -> third scan row 30 ny=768 -> wr_y=-162, recycled, wr_act nonzero, rows_recycled=1.
REQ-035 scroll_amt=63 -> treated as 29; row 0 wr_y=-133 after one scan from reset.
REQ-036 frame_start at cycle 5 of a scan -> scan unaffected (31 writes), overrun=1 and stays 1.
REQ-037 rst asserted at scan cycle 12 -> wr_en low next cycle, busy 0, row_y back to initial; next scan with amt=10 gives row 0 wr_y=-152.
REQ-038 frame_start with scroll_amt=0 -> no wr_en, no done, busy stays 0.
